// File: rtl/mem_bist.sv
// mem_bist: built-in self-test sequencer for a synchronous single-port memory.
// Runs up to three write/read-back phases (clear, data=address, LFSR random),
// compares the read data on chip and reports an error count and the address
// of the first mismatch.
//
//  state | meaning
//  ------+-------------------------------------------------------------------
//  IDLE  | waiting for start; strobes low, address/data held at 0
//  CLR_W | write 0 to every address
//  CLR_R | read every address expecting 0, then one drain cycle
//  ADR_W | write every address with its own (zero-extended/truncated) value
//  ADR_R | read back the data=address pattern, then one drain cycle
//  RND_W | write the LFSR sequence started from SEED
//  RND_R | regenerate the LFSR sequence from SEED and read back, then drain
//  DONE  | run complete; done/pass/err_count/first_err_addr held until start
module mem_bist #(
    parameter int          DWIDTH = 8,
    parameter int          AWIDTH = 5,
    parameter int          ERRW   = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        pat_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRW-1:0]   err_count,
    output logic [AWIDTH-1:0] first_err_addr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int XW    = (DWIDTH > AWIDTH) ? DWIDTH : AWIDTH;
    localparam logic [AWIDTH:0] CNT_LAST  = (AWIDTH + 1)'(DEPTH - 1);
    localparam logic [AWIDTH:0] CNT_DRAIN = (AWIDTH + 1)'(DEPTH);
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR_W = 3'd1,
        CLR_R = 3'd2,
        ADR_W = 3'd3,
        ADR_R = 3'd4,
        RND_W = 3'd5,
        RND_R = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t state, state_next;

    // Address counter; in R states it runs one past the last address so the
    // extra count is the drain cycle.
    logic [AWIDTH:0]   cnt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_step;
    // Only the phases after clear need remembering; clear is always first.
    logic [2:1]        pat_q;

    logic              cmp_valid;
    logic [DWIDTH-1:0] cmp_exp;
    logic [AWIDTH-1:0] cmp_addr;
    logic              have_err;

    logic              idle_or_done;
    logic              start_accept;
    logic              abort_now;
    logic              drain;
    logic              mismatch;
    logic              enter_done;
    logic              rnd_entry;
    logic [AWIDTH-1:0] cur_addr;
    logic [XW-1:0]     addr_ext;
    logic [DWIDTH-1:0] pat_data;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign start_accept = idle_or_done && start;
    assign abort_now    = !idle_or_done && abort;
    assign cur_addr     = cnt[AWIDTH-1:0];
    assign drain        = cnt[AWIDTH];
    assign addr_ext     = XW'(cur_addr);
    assign lfsr_step    = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign enter_done   = !idle_or_done && (state_next == DONE);
    assign rnd_entry    = (state_next != state) &&
                          ((state_next == RND_W) || (state_next == RND_R));
    // A compare landing in the abort cycle is dropped with the rest of the run.
    assign mismatch     = cmp_valid && !abort_now && (mem_rdata !== cmp_exp);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: walk the enabled phases in order, abort returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (pat_en[0]) begin
                        state_next = CLR_W;
                    end else if (pat_en[1]) begin
                        state_next = ADR_W;
                    end else if (pat_en[2]) begin
                        state_next = RND_W;
                    end else begin
                        // Empty phase set: one strobe-free drain cycle, then DONE.
                        state_next = CLR_R;
                    end
                end
            end
            CLR_W: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = CLR_R;
                end
            end
            CLR_R: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (drain) begin
                    if (pat_q[1]) begin
                        state_next = ADR_W;
                    end else if (pat_q[2]) begin
                        state_next = RND_W;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ADR_W: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ADR_R;
                end
            end
            ADR_R: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (drain) begin
                    state_next = pat_q[2] ? RND_W : DONE;
                end
            end
            RND_W: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = RND_R;
                end
            end
            RND_R: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (drain) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: strobes, pattern data and status decoded from state and count.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        pat_data  = '0;
        case (state)
            IDLE: ;
            DONE: done = 1'b1;
            CLR_W: begin
                busy      = 1'b1;
                mem_write = 1'b1;
            end
            CLR_R: begin
                busy     = 1'b1;
                mem_read = !drain;
            end
            ADR_W: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                pat_data  = addr_ext[DWIDTH-1:0];
            end
            ADR_R: begin
                busy     = 1'b1;
                mem_read = !drain;
                pat_data = addr_ext[DWIDTH-1:0];
            end
            RND_W: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                pat_data  = lfsr[DWIDTH-1:0];
            end
            RND_R: begin
                busy     = 1'b1;
                mem_read = !drain;
                pat_data = lfsr[DWIDTH-1:0];
            end
            default: ;
        endcase
        mem_addr  = (mem_write || mem_read) ? cur_addr : '0;
        mem_wdata = mem_write ? pat_data : '0;
    end

    // Address counter, phase latch and LFSR; the LFSR restarts from SEED on
    // entry to each random state so the read phase replays the written data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pat_q <= '0;
            lfsr  <= SEED;
        end else begin
            if (start_accept) begin
                pat_q <= pat_en[2:1];
            end
            if (start_accept && (pat_en == 3'b000)) begin
                cnt <= CNT_DRAIN;
            end else if (state_next != state) begin
                cnt <= '0;
            end else if (!idle_or_done) begin
                cnt <= cnt + 1'b1;
            end
            if (rnd_entry) begin
                lfsr <= SEED;
            end else if (((state == RND_W) || (state == RND_R)) &&
                         (mem_write || mem_read)) begin
                lfsr <= lfsr_step;
            end
        end
    end

    // Compare pipeline and run status: expected data/address follow each
    // read by one cycle to line up with the registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid      <= 1'b0;
            cmp_exp        <= '0;
            cmp_addr       <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            have_err       <= 1'b0;
            pass           <= 1'b0;
        end else begin
            cmp_valid <= mem_read && !abort_now;
            cmp_exp   <= pat_data;
            cmp_addr  <= cur_addr;
            if (start_accept) begin
                err_count      <= '0;
                first_err_addr <= '0;
                have_err       <= 1'b0;
                pass           <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!have_err) begin
                        first_err_addr <= cmp_addr;
                        have_err       <= 1'b1;
                    end
                end
                // The final drain compare lands on the same edge as DONE.
                if (enter_done) begin
                    pass <= !(have_err || mismatch);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Testbench for mem_bist: memory model with injectable read faults, a table of
// directed runs, randomized runs against a phase-level reference model, and
// hand sequences for abort, held start and mid-run reset.
module tb_mem_bist;

    localparam int          DW    = 8;
    localparam int          AW    = 5;
    localparam int          EW    = 4;
    localparam int          DEPTH = 32;
    localparam int          LIMIT = 1000;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        logic [2:0] pat;
        int         fault;
        int         n;
        int         err;
        int         first;
        logic       pass;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    pat_en = 3'b000;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    // Memory environment state.
    logic [DW-1:0]      mem [DEPTH];
    int                 fault_mode = 0;
    int                 f_addr     = 0;
    int                 f_bit      = 0;
    logic [AW+DW-1:0]   wlog [$];
    logic [AW-1:0]      rlog [$];
    int                 strobe_bad = 0;

    always #5 clk = ~clk;

    mem_bist #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .ERRW  (EW),
        .SEED  (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .pat_en        (pat_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_rdata     (mem_rdata)
    );

    // Read-path faults: 1 bit1 stuck high at address 5, 2 all reads 0xFF,
    // 3 bit f_bit flipped at f_addr, 4 bit f_bit stuck high at f_addr.
    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] m;
        m = DW'(1) << f_bit;
        case (fault_mode)
            1:       return (a == 5) ? (v | 8'h02) : v;
            2:       return '1;
            3:       return (a == f_addr) ? (v ^ m) : v;
            4:       return (a == f_addr) ? (v | m) : v;
            default: return v;
        endcase
    endfunction

    // Synchronous memory with registered read, plus strobe logging.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (mem_read) begin
            mem_rdata <= faulty(mem[mem_addr], int'(mem_addr));
            rlog.push_back(mem_addr);
        end
        if (mem_write && mem_read) strobe_bad = strobe_bad + 1;
        if (!busy && (mem_write || mem_read || mem_addr != '0 || mem_wdata != '0))
            strobe_bad = strobe_bad + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Data written to address a in phase ph (0 clear, 1 data=address, 2 random).
    function automatic logic [DW-1:0] pattern(input int ph, input int a);
        logic [15:0] r;
        r = SEED;
        if (ph == 0) return '0;
        if (ph == 1) return DW'(a);
        for (int i = 0; i < a; i++) r = lfsr_next(r);
        return r[DW-1:0];
    endfunction

    task automatic model_run(input logic [2:0] p, output int n, output int err,
                             output int first, output logic ps);
        bit found;
        logic [DW-1:0] v;
        n = 0; err = 0; first = 0; found = 0;
        for (int ph = 0; ph < 3; ph++) begin
            if (p[ph]) begin
                n += 2 * DEPTH + 1;
                for (int a = 0; a < DEPTH; a++) begin
                    v = pattern(ph, a);
                    if (faulty(v, a) !== v) begin
                        err++;
                        if (!found) begin
                            first = a;
                            found = 1;
                        end
                    end
                end
            end
        end
        if (n == 0) n = 1;
        ps = (err == 0);
        if (err > (1 << EW) - 1) err = (1 << EW) - 1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] p);
        pat_en = p;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] p, input int e_n,
                             input int e_err, input int e_first, input logic e_pass);
        int n;
        int busy_bad;
        int idx;
        int bad;
        wlog.delete();
        rlog.delete();
        strobe_bad = 0;
        do_start(p);
        n = 0;
        busy_bad = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".cycles"}, n, e_n);
        check({tag, ".busy_run"}, busy_bad, 0);
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".err_count"}, err_count, e_err);
        check({tag, ".first_err"}, first_err_addr, e_first);
        check({tag, ".pass"}, pass, e_pass);
        check({tag, ".strobes"}, strobe_bad, 0);
        idx = 0; bad = 0;
        for (int ph = 0; ph < 3; ph++)
            if (p[ph])
                for (int a = 0; a < DEPTH; a++) begin
                    if (idx >= wlog.size() || wlog[idx] !== {AW'(a), pattern(ph, a)}) bad++;
                    idx++;
                end
        if (wlog.size() != idx) bad++;
        check({tag, ".wr_seq"}, bad, 0);
        idx = 0; bad = 0;
        for (int ph = 0; ph < 3; ph++)
            if (p[ph])
                for (int a = 0; a < DEPTH; a++) begin
                    if (idx >= rlog.size() || rlog[idx] !== AW'(a)) bad++;
                    idx++;
                end
        if (rlog.size() != idx) bad++;
        check({tag, ".rd_seq"}, bad, 0);
    endtask

    task automatic run_model(input string tag, input logic [2:0] p);
        int n, err, first;
        logic ps;
        model_run(p, n, err, first, ps);
        run_check(tag, p, n, err, first, ps);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[8];
        int   n;
        logic [2:0] p;

        tbl[0] = '{3'b111, 0, 195, 0,  0, 1'b1};
        tbl[1] = '{3'b001, 1,  65, 1,  5, 1'b0};
        tbl[2] = '{3'b010, 1,  65, 1,  5, 1'b0};
        tbl[3] = '{3'b011, 2, 130, 15, 0, 1'b0};
        tbl[4] = '{3'b001, 2,  65, 15, 0, 1'b0};
        tbl[5] = '{3'b000, 2,   1, 0,  0, 1'b1};
        tbl[6] = '{3'b101, 0, 130, 0,  0, 1'b1};
        tbl[7] = '{3'b100, 0,  65, 0,  0, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, pass, err_count, first_err_addr,
                                mem_addr, mem_wdata, mem_write, mem_read}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", {busy, done}, 0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            fault_mode = tbl[i].fault;
            run_check($sformatf("vec%0d", i), tbl[i].pat, tbl[i].n, tbl[i].err,
                      tbl[i].first, tbl[i].pass);
        end

        // Randomized runs against the reference model.
        for (int i = 0; i < 12; i++) begin
            fault_mode = $urandom_range(0, 4);
            f_addr     = $urandom_range(0, DEPTH - 1);
            f_bit      = $urandom_range(0, DW - 1);
            p          = 3'($urandom_range(0, 7));
            run_model($sformatf("rnd%0d", i), p);
        end

        // Abort 40 cycles in, with one known error already counted.
        fault_mode = 3; f_addr = 2; f_bit = 0;
        do_start(3'b111);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort.busy_done", {busy, done}, 0);
        check("abort.strobes", {mem_write, mem_read, mem_addr, mem_wdata}, 0);
        check("abort.err_hold", err_count, 1);
        check("abort.first_hold", first_err_addr, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort.stays_idle", {busy, done}, 0);
        fault_mode = 0;
        run_check("abort_rerun", 3'b111, 195, 0, 0, 1'b1);

        // Start held high across a whole run; pat_en change mid-run ignored.
        pat_en = 3'b001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            if (n == 5) pat_en = 3'b111;
            @(posedge clk);
            #1;
            n++;
        end
        check("held.cycles", n, 65);
        pat_en = 3'b001;
        @(posedge clk);
        #1;
        check("held.restart", {busy, done}, 2'b10);
        start = 1'b0;
        wait_done(n);
        check("held.rerun_cycles", n, 65);
        check("held.err", err_count, 0);

        // abort together with start from DONE: start wins.
        pat_en = 3'b001;
        start  = 1'b1;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_over_abort", busy, 1);
        wait_done(n);
        check("start_over_abort.cycles", n, 65);
        // abort in DONE has no effect.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_in_done", {done, pass}, 2'b11);

        // Asynchronous reset mid-run.
        do_start(3'b111);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("midrun.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrun.async_clear", {busy, done, pass, err_count, first_err_addr,
                                     mem_addr, mem_wdata, mem_write, mem_read}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("midrun.idle_after", {busy, done, mem_write, mem_read}, 0);
        run_check("post_reset", 3'b010, 65, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
